// File: rtl/prog_loader.sv
// Byte-stream program loader: frames addr/count/words into flash writes.
// Optional trailing XOR checksum byte enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] flash_addr,
    output logic [WIDTH-1:0] flash_data,
    output logic             flash_en,
    output logic             core_rst,
    output logic             done,
    output logic             error
);

    typedef enum logic [2:0] {
        S_ADDR,
        S_COUNT,
        S_DATA,
        S_WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t           state_q, state_d;
    logic [1:0]       bcnt_q;
    logic [23:0]      field_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] word;
    logic             xfer;
    logic             last_byte;
    logic             ready_d;

    logic             in_ready_q;
    logic [WIDTH-1:0] flash_addr_q;
    logic [WIDTH-1:0] flash_data_q;
    logic             flash_en_q;
    logic             core_rst_q;
    logic             done_q;
    logic             error_q;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]       csum_q;
`endif

    assign xfer      = in_valid & in_ready_q;
    assign last_byte = (bcnt_q == 2'd3);
    // Bytes arrive LSB first, so the newest byte lands on top.
    assign word      = {in_data, field_q};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_ADDR: begin
                if (xfer && last_byte)
                    state_d = (word[1:0] != 2'b00) ? S_ERR : S_COUNT;
            end
            S_COUNT: begin
                if (xfer && last_byte)
                    state_d = (word == '0) ? S_TAIL : S_DATA;
            end
            S_DATA: begin
                if (xfer && last_byte)
                    state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = (cnt_q == WIDTH'(1)) ? S_TAIL : S_DATA;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer)
                    state_d = (in_data == csum_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        ready_d = (state_d == S_ADDR) || (state_d == S_COUNT) ||
                  (state_d == S_DATA);
`ifdef PROG_LOADER_CHECKSUM_EN
        if (state_d == S_CSUM)
            ready_d = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_ADDR;
            bcnt_q       <= '0;
            field_q      <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            flash_addr_q <= '0;
            flash_data_q <= '0;
            flash_en_q   <= 1'b0;
            core_rst_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            in_ready_q <= ready_d;
            flash_en_q <= (state_d == S_WRITE);
            done_q     <= (state_d == S_DONE);
            error_q    <= (state_d == S_ERR);
            core_rst_q <= (state_d != S_DONE);

            if (xfer) begin
                field_q <= word[WIDTH-1:8];
                bcnt_q  <= bcnt_q + 2'd1;
            end
            if (xfer && last_byte && state_q == S_ADDR)
                addr_q <= word;
            if (xfer && last_byte && state_q == S_COUNT)
                cnt_q <= word;
            if (state_q == S_DATA && state_d == S_WRITE) begin
                flash_data_q <= word;
                flash_addr_q <= addr_q;
            end
            // Address wraps silently past the top of the space.
            if (state_q == S_WRITE) begin
                addr_q <= addr_q + WIDTH'(4);
                cnt_q  <= cnt_q - WIDTH'(1);
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            if (xfer && state_q == S_DATA)
                csum_q <= csum_q ^ in_data;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign flash_addr = flash_addr_q;
    assign flash_data = flash_data_q;
    assign flash_en   = flash_en_q;
    assign core_rst   = core_rst_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; writes captured by a negedge monitor.
// Follows PROG_LOADER_CHECKSUM_EN to append the checksum byte.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [31:0] flash_addr;
    logic [31:0] flash_data;
    logic        flash_en;
    logic        core_rst;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic        prev_en = 1'b0;
    int          dbl = 0;
    logic [7:0]  tb_csum;

    always #5 clk = ~clk;

    prog_loader #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .flash_addr (flash_addr),
        .flash_data (flash_data),
        .flash_en   (flash_en),
        .core_rst   (core_rst),
        .done       (done),
        .error      (error)
    );

    always @(negedge clk) begin
        if (flash_en) begin
            wa.push_back(flash_addr);
            wd.push_back(flash_data);
            if (prev_en) dbl++;
        end
        prev_en = flash_en;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst      = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        tb_csum = 8'h00;
        wa.delete();
        wd.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) begin
            chk("hs_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (gap) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit pay,
                             input bit gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], gap);
            if (pay) tb_csum = tb_csum ^ w[8*i +: 8];
        end
    endtask

    task automatic finish_frame(input bit gap);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(tb_csum, gap);
`endif
        in_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (!(done || error) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!(done || error))
            chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_en", {31'd0, flash_en}, 32'd0);
        chk("rst_core", {31'd0, core_rst}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, error}, 32'd0);
        chk("rst_addr", flash_addr, 32'd0);
        chk("rst_data", flash_data, 32'd0);

        // continuous two-word load
        do_reset();
        send_word(32'h0000_0000, 1'b0, 1'b0);
        send_word(32'h0000_0002, 1'b0, 1'b0);
        send_word(32'h0240_2783, 1'b1, 1'b0);
        @(negedge clk);
        chk("lat_en", {31'd0, flash_en}, 32'd1);
        chk("lat_data", flash_data, 32'h0240_2783);
        send_word(32'h0280_2803, 1'b1, 1'b0);
`ifndef PROG_LOADER_CHECKSUM_EN
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat2_en", {31'd0, flash_en}, 32'd1);
        @(negedge clk);
        chk("done_1cyc", {31'd0, done}, 32'd1);
        chk("core_1cyc", {31'd0, core_rst}, 32'd0);
`endif
        finish_frame(1'b0);
        wait_end("t1");
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_core", {31'd0, core_rst}, 32'd0);
        chk("t1_nw", wa.size(), 32'd2);
        if (wa.size() == 2) begin
            chk("t1_a0", wa[0], 32'h0000_0000);
            chk("t1_d0", wd[0], 32'h0240_2783);
            chk("t1_a1", wa[1], 32'h0000_0004);
            chk("t1_d1", wd[1], 32'h0280_2803);
        end
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(negedge clk);
        chk("t1_stall", {31'd0, in_ready}, 32'd0);
        chk("t1_sticky", {31'd0, done}, 32'd1);

        // same frame, in_valid toggling
        do_reset();
        send_word(32'h0000_0000, 1'b0, 1'b1);
        send_word(32'h0000_0002, 1'b0, 1'b1);
        send_word(32'h0240_2783, 1'b1, 1'b1);
        send_word(32'h0280_2803, 1'b1, 1'b1);
        finish_frame(1'b1);
        wait_end("t2");
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_nw", wa.size(), 32'd2);
        if (wa.size() == 2) begin
            chk("t2_a0", wa[0], 32'h0000_0000);
            chk("t2_d0", wd[0], 32'h0240_2783);
            chk("t2_a1", wa[1], 32'h0000_0004);
            chk("t2_d1", wd[1], 32'h0280_2803);
        end

        // misaligned start address
        do_reset();
        send_word(32'h0000_0026, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h01;
        @(negedge clk);
        chk("t3_err", {31'd0, error}, 32'd1);
        chk("t3_core", {31'd0, core_rst}, 32'd1);
        chk("t3_ready", {31'd0, in_ready}, 32'd0);
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        chk("t3_nw", wa.size(), 32'd0);
        chk("t3_done", {31'd0, done}, 32'd0);

        // empty image
        do_reset();
        send_word(32'h0000_0024, 1'b0, 1'b0);
        send_word(32'h0000_0000, 1'b0, 1'b0);
        finish_frame(1'b0);
        wait_end("t4");
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_err", {31'd0, error}, 32'd0);
        chk("t4_nw", wa.size(), 32'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
        do_reset();
        send_word(32'h0000_0024, 1'b0, 1'b0);
        send_word(32'h0000_0000, 1'b0, 1'b0);
        send_byte(8'h5A, 1'b0);
        in_valid = 1'b0;
        wait_end("t4b");
        chk("t4b_err", {31'd0, error}, 32'd1);
        chk("t4b_done", {31'd0, done}, 32'd0);
        chk("t4b_core", {31'd0, core_rst}, 32'd1);
`endif

        // address wrap
        do_reset();
        send_word(32'hFFFF_FFFC, 1'b0, 1'b0);
        send_word(32'h0000_0002, 1'b0, 1'b0);
        send_word(32'hA5A5_0001, 1'b1, 1'b0);
        send_word(32'h1234_5678, 1'b1, 1'b0);
        finish_frame(1'b0);
        wait_end("t5");
        chk("t5_done", {31'd0, done}, 32'd1);
        chk("t5_nw", wa.size(), 32'd2);
        if (wa.size() == 2) begin
            chk("t5_a0", wa[0], 32'hFFFF_FFFC);
            chk("t5_d0", wd[0], 32'hA5A5_0001);
            chk("t5_a1", wa[1], 32'h0000_0000);
            chk("t5_d1", wd[1], 32'h1234_5678);
        end

        // reset mid-frame then fresh frame
        do_reset();
        send_word(32'h0000_0000, 1'b0, 1'b0);
        send_word(32'h0000_0001, 1'b0, 1'b0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        tb_csum = 8'h00;
        @(negedge clk);
        chk("t6_core", {31'd0, core_rst}, 32'd1);
        send_word(32'h0000_0024, 1'b0, 1'b0);
        send_word(32'h0000_0001, 1'b0, 1'b0);
        send_word(32'h0000_0001, 1'b1, 1'b0);
        finish_frame(1'b0);
        wait_end("t6");
        chk("t6_done", {31'd0, done}, 32'd1);
        chk("t6_nw", wa.size(), 32'd1);
        if (wa.size() == 1) begin
            chk("t6_a0", wa[0], 32'h0000_0024);
            chk("t6_d0", wd[0], 32'h0000_0001);
        end

        chk("no_double_en", dbl, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
